// File: rtl/div_iter_unit_pkg.sv
// Shared types and constants for the iterative divider.
package div_iter_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  // Divider FSM state codes.
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // Handshake levels.
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_iter_unit.sv
// Multi-cycle restoring radix-2 divider, signed (DIV) or unsigned (DIVU).
// Produces {remainder, quotient} for HI/LO with a level start/ready handshake.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(WIDTH - 1);

  // Registered state and datapath.
  div_state_e           r_state;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_dvd;
  logic [WIDTH-1:0]     r_dsr;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic                 r_neg_quo;
  logic                 r_neg_rem;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_ready;

  // Next-state values.
  div_state_e           w_state_nxt;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [WIDTH-1:0]     w_dvd_nxt;
  logic [WIDTH-1:0]     w_dsr_nxt;
  logic [DIV_CNT_W-1:0] w_cnt_nxt;
  logic                 w_neg_quo_nxt;
  logic                 w_neg_rem_nxt;
  logic [2*WIDTH-1:0]   w_result_nxt;
  logic                 w_ready_nxt;

  // Datapath helpers.
  logic                 w_op1_neg;
  logic                 w_op2_neg;
  logic [WIDTH-1:0]     w_op1_abs;
  logic [WIDTH-1:0]     w_op2_abs;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH+1:0]     w_sub;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // Operand magnitudes: negate only for signed divides with a negative operand.
  always_comb begin
    w_op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    w_op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    w_op1_abs = w_op1_neg ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    w_op2_abs = w_op2_neg ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
  end

  // One restoring step: shift {rem,dvd} left, trial-subtract the divisor.
  always_comb begin
    w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    w_sub    = {1'b0, w_rem_sh} - {2'b00, r_dsr};
    w_ge     = ~w_sub[WIDTH+1];
  end

  // Sign correction of the final magnitudes; remainder follows the dividend.
  always_comb begin
    w_quo_fix = r_neg_quo ? (~r_dvd + WIDTH'(1)) : r_dvd;
    w_rem_fix = r_neg_rem ? (~r_rem + WIDTH'(1)) : r_rem;
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_rem_nxt     = r_rem;
    w_dvd_nxt     = r_dvd;
    w_dsr_nxt     = r_dsr;
    w_cnt_nxt     = r_cnt;
    w_neg_quo_nxt = r_neg_quo;
    w_neg_rem_nxt = r_neg_rem;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;

    case (r_state)
      DIV_FREE: begin
        w_ready_nxt  = DIV_RESULT_NOT_READY;
        w_result_nxt = '0;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = DIV_BYZERO;
          end else begin
            w_state_nxt   = DIV_ON;
            w_dvd_nxt     = w_op1_abs;
            w_dsr_nxt     = w_op2_abs;
            w_rem_nxt     = '0;
            w_cnt_nxt     = '0;
            w_neg_quo_nxt = w_op1_neg ^ w_op2_neg;
            w_neg_rem_nxt = w_op1_neg;
          end
        end
      end

      DIV_BYZERO: begin
        w_state_nxt   = DIV_END;
        w_rem_nxt     = '0;
        w_dvd_nxt     = '0;
        w_neg_quo_nxt = 1'b0;
        w_neg_rem_nxt = 1'b0;
      end

      DIV_ON: begin
        if (annul_i || start_i == DIV_STOP) begin
          w_state_nxt  = DIV_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end else begin
          w_rem_nxt = w_ge ? w_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          w_dvd_nxt = {r_dvd[WIDTH-2:0], w_ge};
          w_cnt_nxt = r_cnt + DIV_CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = DIV_END;
          end
        end
      end

      DIV_END: begin
        if (start_i == DIV_START) begin
          w_ready_nxt  = DIV_RESULT_READY;
          w_result_nxt = {w_rem_fix, w_quo_fix};
        end else begin
          w_state_nxt  = DIV_FREE;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
          w_result_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = DIV_FREE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DIV_FREE;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dsr     <= '0;
      r_cnt     <= '0;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
      r_ready   <= DIV_RESULT_NOT_READY;
    end else begin
      r_state   <= w_state_nxt;
      r_rem     <= w_rem_nxt;
      r_dvd     <= w_dvd_nxt;
      r_dsr     <= w_dsr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_neg_quo <= w_neg_quo_nxt;
      r_neg_rem <= w_neg_rem_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit against an arithmetic reference model.
module tb_div_iter_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks;
  int failures;

  div_iter_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {remainder, quotient} from plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start with operands; return edges until ready (edge t is index 0) and the result.
  // Operands are scrambled after the first edge since the divider must have latched them.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output int lat, output logic [63:0] res);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = 60;
    res          = 64'd0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (k == 0) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
      if (ready_o) begin
        lat = k;
        res = result_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    repeat (3) tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      failures++;
      $display("FAIL reset: ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
    end
    rst = 1'b0;
    tick();
  endtask

  // Full divide with latency check, result check and release check.
  task automatic check_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn);
    int lat;
    int exp_lat;
    logic [63:0] res;
    logic [63:0] exp_res;
    exp_res = ref_div(a, b, sgn);
    exp_lat = (b == 32'd0) ? 2 : 33;
    run_div(a, b, sgn, lat, res);
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (res !== exp_res) begin
      failures++;
      $display("FAIL %s result: a=%h b=%h s=%b got %h expected %h", name, a, b, sgn, res, exp_res);
    end
    start_i = 1'b0;
    tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      failures++;
      $display("FAIL %s release: ready=%b result=%h expected 0/0", name, ready_o, result_o);
    end
  endtask

  task automatic test_divu_basic();
    check_div("divu_100_7", 32'd100, 32'd7, 1'b0);
    checks++;
    if (ref_div(32'd100, 32'd7, 1'b0) !== {32'd2, 32'd14}) begin
      failures++;
      $display("FAIL model_100_7: got %h expected %h", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    end
  endtask

  task automatic test_signed();
    check_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    check_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    check_div("div_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
  endtask

  task automatic test_div_zero();
    check_div("div_5_0", 32'd5, 32'd0, 1'b1);
    check_div("divu_5_0", 32'd5, 32'd0, 1'b0);
  endtask

  task automatic test_overflow();
    check_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check_div("divu_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'($urandom_range(2, 15));
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      check_div("random", a, b, s);
    end
  endtask

  task automatic test_annul();
    logic seen;
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (11) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    start_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready_o || result_o !== 64'd0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL annul: outputs became nonzero after annul (ready=%b result=%h)", ready_o, result_o);
    end
    check_div("after_annul", 32'hFFFF_FFFF, 32'd16, 1'b0);
  endtask

  task automatic test_reset_mid();
    signed_div_i = 1'b1;
    opdata1_i = 32'h1234_5678;
    opdata2_i = 32'd9;
    start_i = 1'b1;
    repeat (21) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid: ready=%b result=%h expected 0/0", ready_o, result_o);
    end
    rst = 1'b0;
    start_i = 1'b0;
    tick();
    check_div("after_reset", 32'hFFFF_FF00, 32'd7, 1'b1);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] res;
    logic [63:0] exp1;
    logic        stable;
    exp1 = ref_div(32'd123456, 32'd789, 1'b0);
    run_div(32'd123456, 32'd789, 1'b0, lat, res);
    checks++;
    if (lat != 33 || res !== exp1) begin
      failures++;
      $display("FAIL b2b_first: lat=%0d result=%h expected 33 %h", lat, res, exp1);
    end
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ready_o !== 1'b1 || result_o !== exp1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL b2b_hold: ready=%b result=%h expected 1 %h", ready_o, result_o, exp1);
    end
    start_i = 1'b0;
    tick();
    check_div("b2b_second", 32'hDEAD_BEEF, 32'hFFFF_FFF3, 1'b1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
